uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Round-robin scheduler that shares a single UART byte transmitter among `NREQ` independent requesters. Each requester presents bytes over a valid/ready handshake and may hold the channel for a multi-byte burst, up to `BURST_MAX` bytes or until it marks a byte `last`. The block sits between the board-level message sources (button/status/debug producers) and the UART transmitter. It drives the transmitter's load strobe and data, and tracks the transmitter's busy flag to know when each byte is finished.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `BURST_MAX`, 16: maximum bytes per grant, 1..255.
- `ACK_TIMEOUT`, 255: cycles allowed after `tx_start` for `tx_busy` to rise, 1..65535.
- Derived: `IW` = clog2(`NREQ`).
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in `NREQ`: per-requester byte available.
- `req_data` in 8*`NREQ`: byte of requester i is `req_data[8i+7:8i]`.
- `req_last` in `NREQ`: byte currently offered ends that requester's burst.
- `req_ready` out `NREQ`: one-hot handshake; a byte transfers when `req_valid[i]` and `req_ready[i]` are both high on a rising edge.
- `tx_start` out 1: one-cycle load strobe to the UART transmitter.
- `tx_data` out 8: byte for the transmitter; valid while `tx_start` is high and held until the next load.
- `tx_busy` in 1: transmitter is sending a frame.
- `grant_id` out `IW`: index of the current grant holder.
- `active` out 1: a grant is held (state is not ARB).
- `err_timeout` out 1: sticky; set when `tx_busy` fails to rise within `ACK_TIMEOUT` cycles.

## Operation
- States: ARB, SEND, WAIT_ACK, WAIT_DONE.
- **ARB**
  - Search `req_valid` starting at `ptr`, wrapping modulo `NREQ`.
  - First set bit i: register `grant_id`←i, burst count←0, go to SEND.
  - No valid request: stay in ARB.
- **SEND**
  - `req_ready[grant_id]` = `req_valid[grant_id]` (combinational, only in this state); all other ready bits are 0.
  - On a transfer: `tx_data`←byte, capture `last`, increment burst count, go to WAIT_ACK.
  - If `req_valid[grant_id]` is low: release the grant, `ptr`←`grant_id`+1 (mod `NREQ`), go to ARB.
- **WAIT_ACK**
  - `tx_start` is high for exactly the first cycle in this state.
  - `tx_busy` high: go to WAIT_DONE.
  - Otherwise the counter increments. When it reaches `ACK_TIMEOUT`: set `err_timeout`, release the grant (`ptr` advances), go to ARB. The byte is dropped.
- **WAIT_DONE**
  - Wait for `tx_busy` low.
  - Then, if captured `last` = 1 or burst count = `BURST_MAX`: `ptr`←`grant_id`+1, go to ARB.
  - Otherwise go to SEND with the grant kept.
- `ptr` wraps from `NREQ`-1 to 0.
- The burst counter is 8 bits and never exceeds `BURST_MAX`.
- The timeout counter is 16 bits and clears on entry to WAIT_ACK.
- `err_timeout` clears only on `reset`.
- `req_data` and `req_last` are sampled only on the handshake cycle.
- Other requesters' inputs are ignored while a grant is held.
- Reset values: state ARB, `ptr` 0, `grant_id` 0, `tx_start` 0, `tx_data` 0x00, `req_ready` 0, `active` 0, `err_timeout` 0, counters 0.
- Reset asserted mid-operation aborts everything on that edge. No `tx_start` is emitted afterwards, and any byte already accepted but not yet started is lost.

## Timing
- Edge 0: ARB sees a valid request.
- Edge 1: enters SEND; `req_ready` is high during this cycle.
- Edge 2: handshake completes, `tx_data` updates.
- Cycle after edge 2: `tx_start` is high.
- Minimum latency from `req_valid` to `tx_start` is therefore 3 cycles.
- Back-to-back bytes in one burst: `tx_busy` falls → SEND on the next edge → `tx_start` 2 cycles later.
- `tx_busy` already high on the `tx_start` cycle: counted as the acknowledgement, so the transition to WAIT_DONE happens on that edge.
- Grant switch costs one ARB cycle.
- A requester that re-asserts `req_valid` while still at lowest priority waits a full round.

## Test plan
- **Single byte:** only req 2 valid, data 0xA5, last=1, model busy high for 10 cycles starting 1 cycle after `tx_start` → `tx_start` at 3 cycles, `tx_data`=0xA5, `grant_id`=2, then ARB with `ptr`=3.
- **Round robin:** all 4 requesters continuously valid with last=1 → grant order 0,1,2,3,0, one byte each.
- **Burst cap:** `BURST_MAX`=3, req 1 offers 5 bytes with last=0 → 3 bytes sent, then grant moves to req 2 (also valid); req 1 resumes on the next round.
- **Burst end:** req 0 sends 0x11, 0x22 (last=1) with req 3 valid → exactly 2 bytes, then `grant_id`=3.
- **Timeout:** `tx_busy` held 0, `ACK_TIMEOUT`=8 → `err_timeout` rises 8 cycles after `tx_start`, state returns to ARB, next requester served, flag stays high until `reset`.
- **Reset:** `reset` asserted while in WAIT_DONE → next cycle all outputs at reset values, `ptr`=0, `req_ready` low.

Source files
------------

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART byte transmitter among NREQ requesters,
// with bounded bursts, per-byte busy tracking and a sticky acknowledge timeout.
module uart_tx_sched #(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned BURST_MAX   = 16,
    parameter int unsigned ACK_TIMEOUT = 255,
    localparam int unsigned IW         = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    output logic [IW-1:0]     grant_id,
    output logic              active,
    output logic              err_timeout
);

    localparam int unsigned BW = 8;
    localparam int unsigned TW = 16;

    typedef enum logic [1:0] {
        ARB,
        SEND,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   grant_d;
    logic [BW-1:0]   bcnt_q, bcnt_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic            last_q, last_d;
    logic [7:0]      tx_data_d;
    logic            tx_start_d;
    logic            err_d;
    logic            active_d;

    logic            arb_hit;
    logic [IW-1:0]   arb_idx;
    logic [IW-1:0]   release_ptr;
    int unsigned     cand;

    // Rotating priority search starting at ptr_q
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        cand    = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = (32'(ptr_q) + k) % NREQ;
            if (!arb_hit && req_valid[IW'(cand)]) begin
                arb_hit = 1'b1;
                arb_idx = IW'(cand);
            end
        end
    end

    assign release_ptr = (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + IW'(1);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_id;
        bcnt_d     = bcnt_q;
        tcnt_d     = tcnt_q;
        last_d     = last_q;
        tx_data_d  = tx_data;
        tx_start_d = 1'b0;
        err_d      = err_timeout;
        req_ready  = '0;

        unique case (state_q)
            ARB: begin
                if (arb_hit) begin
                    grant_d = arb_idx;
                    bcnt_d  = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                req_ready[grant_id] = req_valid[grant_id];
                if (req_valid[grant_id]) begin
                    tx_data_d  = req_data[{grant_id, 3'b000} +: 8];
                    last_d     = req_last[grant_id];
                    bcnt_d     = bcnt_q + BW'(1);
                    tcnt_d     = '0;
                    tx_start_d = 1'b1;
                    state_d    = WAIT_ACK;
                end else begin
                    ptr_d   = release_ptr;
                    state_d = ARB;
                end
            end
            WAIT_ACK: begin
                // Busy already high on the strobe cycle counts as the acknowledge
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                    if (tcnt_d == TW'(ACK_TIMEOUT)) begin
                        err_d   = 1'b1;
                        ptr_d   = release_ptr;
                        state_d = ARB;
                    end
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (last_q || (bcnt_q == BW'(BURST_MAX))) begin
                        ptr_d   = release_ptr;
                        state_d = ARB;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            default: state_d = ARB;
        endcase

        active_d = (state_d != ARB);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB;
            ptr_q       <= '0;
            grant_id    <= '0;
            bcnt_q      <= '0;
            tcnt_q      <= '0;
            last_q      <= 1'b0;
            tx_data     <= 8'h00;
            tx_start    <= 1'b0;
            err_timeout <= 1'b0;
            active      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_id    <= grant_d;
            bcnt_q      <= bcnt_d;
            tcnt_q      <= tcnt_d;
            last_q      <= last_d;
            tx_data     <= tx_data_d;
            tx_start    <= tx_start_d;
            err_timeout <= err_d;
            active      <= active_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: queue-fed requesters, a UART busy model and a
// transaction-level round-robin/burst model predicting the transmitted byte order.
module tb_uart_tx_sched;

    localparam int NREQ  = 4;
    localparam int BMAX  = 3;
    localparam int ACKTO = 8;
    localparam int QD    = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy = 1'b0;
    logic [1:0]  grant_id;
    logic        active;
    logic        err_timeout;

    uart_tx_sched #(.NREQ(NREQ), .BURST_MAX(BMAX), .ACK_TIMEOUT(ACKTO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .grant_id(grant_id), .active(active),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Requester byte queues: {last, data}
    logic [8:0] rq [NREQ][QD];
    int rhead [NREQ];
    int rtail [NREQ];

    logic [9:0] obs_q[$];
    logic [9:0] exp_q[$];
    int m_ptr = 0;

    int  blen = 3;
    bit  stuck = 1'b0;
    bit  pend = 1'b0;
    int  bleft = 0;
    logic [3:0] hs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_heads();
        for (int i = 0; i < NREQ; i++) begin
            if (rhead[i] != rtail[i]) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = rq[i][rhead[i]][7:0];
                req_last[i]        = rq[i][rhead[i]][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'($urandom);
                req_last[i]        = 1'($urandom);
            end
        end
    endtask

    // Requester side: present queue heads, pop on completed handshakes
    always begin
        @(negedge clk);
        #1;
        drive_heads();
        #1;
        hs = reset ? 4'b0000 : (req_valid & req_ready);
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++)
            if (hs[i]) rhead[i]++;
    end

    // UART model: busy rises one cycle after the strobe and lasts blen cycles
    always @(posedge clk) begin
        #1;
        if (reset) begin
            tx_busy = 1'b0;
            bleft   = 0;
            pend    = 1'b0;
        end else begin
            if (bleft > 0) begin
                bleft--;
                if (bleft == 0) tx_busy = 1'b0;
            end
            if (pend) begin
                pend    = 1'b0;
                tx_busy = 1'b1;
                bleft   = blen;
            end
            if (tx_start) begin
                obs_q.push_back({grant_id, tx_data});
                if (!stuck) pend = 1'b1;
            end
        end
    end

    task automatic clear_q();
        for (int i = 0; i < NREQ; i++) begin
            rhead[i] = 0;
            rtail[i] = 0;
        end
    endtask

    task automatic load(input int id, input logic [7:0] data, input logic last);
        rq[id][rtail[id]] = {last, data};
        rtail[id]++;
    endtask

    // Expected order: rotate from m_ptr, burst ends on last, cap, or empty queue
    task automatic model_run();
        int h [NREQ];
        int id;
        int n;
        bit done;
        for (int i = 0; i < NREQ; i++) h[i] = rhead[i];
        forever begin
            id = -1;
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (m_ptr + k) % NREQ;
                if (id < 0 && h[c] != rtail[c]) id = c;
            end
            if (id < 0) break;
            n = 0;
            done = 1'b0;
            while (!done) begin
                exp_q.push_back({2'(id), rq[id][h[id]][7:0]});
                n++;
                done = rq[id][h[id]][8] || (n == BMAX);
                h[id]++;
                if (h[id] == rtail[id]) done = 1'b1;
            end
            m_ptr = (id + 1) % NREQ;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        m_ptr = 0;
        @(posedge clk);
        #2;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int c;
        bit idle;
        c = 0;
        idle = 1'b0;
        while (!idle && c < 3000) begin
            @(posedge clk);
            #2;
            c++;
            idle = !active && !tx_busy && !pend;
            for (int i = 0; i < NREQ; i++)
                if (rhead[i] != rtail[i]) idle = 1'b0;
        end
        if (!idle) check({tag, "_idle_bound"}, 32'(c), 32'(0));
    endtask

    task automatic wait_start(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!tx_start && n < 100);
        if (!tx_start) check("start_bound", 32'(n), 32'(0));
    endtask

    task automatic compare_obs(input string tag);
        int m;
        check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < m; i++)
            check({tag, "_byte"}, 32'(obs_q[i]), 32'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int n;
        logic [9:0] e;
        logic [1:0] cap_ids [7];
        clear_q();

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        check("rst_tx_start", 32'(tx_start), 32'(0));
        check("rst_tx_data", 32'(tx_data), 32'(0));
        check("rst_req_ready", 32'(req_ready), 32'(0));
        check("rst_active", 32'(active), 32'(0));
        check("rst_grant", 32'(grant_id), 32'(0));
        check("rst_err", 32'(err_timeout), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        m_ptr = 0;

        // Single byte from requester 2
        blen = 10;
        @(negedge clk);
        clear_q();
        load(2, 8'hA5, 1'b1);
        model_run();
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
            if (n == 1) begin
                check("single_ready", 32'(req_ready), 32'h4);
                check("single_active", 32'(active), 32'(1));
            end
        end while (!tx_start && n < 20);
        // valid-visible ARB cycle, SEND cycle, then the strobe cycle
        check("single_latency", 32'(n), 32'(2));
        check("single_data", 32'(tx_data), 32'hA5);
        check("single_grant", 32'(grant_id), 32'(2));
        @(posedge clk);
        #2;
        check("single_strobe_width", 32'(tx_start), 32'(0));
        wait_idle("single");
        check("single_release", 32'(active), 32'(0));
        compare_obs("single");

        // ptr is now 3: requester 3 beats requester 0
        blen = 2;
        @(negedge clk);
        clear_q();
        load(0, 8'h10, 1'b1);
        load(3, 8'h33, 1'b1);
        model_run();
        wait_idle("ptr");
        if (obs_q.size() > 0) begin
            e = obs_q[0];
            check("ptr_first_grant", 32'(e[9:8]), 32'(3));
        end else check("ptr_first_grant", 32'(0), 32'(1));
        compare_obs("ptr");

        // Round robin, one byte per grant
        do_reset();
        @(negedge clk);
        clear_q();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NREQ; i++) load(i, 8'(16 * i + r), 1'b1);
        model_run();
        wait_idle("rr");
        for (int k = 0; k < 5; k++) begin
            if (k < obs_q.size()) begin
                e = obs_q[k];
                check("rr_order", 32'(e[9:8]), 32'(k % NREQ));
            end
        end
        compare_obs("rr");

        // Burst cap at 3 bytes
        do_reset();
        @(negedge clk);
        clear_q();
        for (int b = 0; b < 5; b++) load(1, 8'(8'hB0 + b), 1'b0);
        load(2, 8'hC0, 1'b1);
        load(2, 8'hC1, 1'b1);
        model_run();
        wait_idle("cap");
        cap_ids = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd2};
        check("cap_len", 32'(obs_q.size()), 32'(7));
        for (int k = 0; k < 7; k++) begin
            if (k < obs_q.size()) begin
                e = obs_q[k];
                check("cap_order", 32'(e[9:8]), 32'(cap_ids[k]));
            end
        end
        compare_obs("cap");

        // Burst end on last
        do_reset();
        @(negedge clk);
        clear_q();
        load(0, 8'h11, 1'b0);
        load(0, 8'h22, 1'b1);
        load(3, 8'h33, 1'b1);
        model_run();
        wait_idle("bend");
        check("bend_len", 32'(obs_q.size()), 32'(3));
        if (obs_q.size() == 3) begin
            check("bend_b0", 32'(obs_q[0]), 32'({2'd0, 8'h11}));
            check("bend_b1", 32'(obs_q[1]), 32'({2'd0, 8'h22}));
            check("bend_b2", 32'(obs_q[2]), 32'({2'd3, 8'h33}));
        end
        compare_obs("bend");

        // Acknowledge timeout
        do_reset();
        @(negedge clk);
        clear_q();
        stuck = 1'b1;
        load(1, 8'h5A, 1'b1);
        load(2, 8'h6B, 1'b1);
        model_run();
        wait_start(n);
        check("to_grant", 32'(grant_id), 32'(1));
        for (int k = 1; k <= ACKTO; k++) begin
            @(posedge clk);
            #2;
            if (k == ACKTO - 1) check("to_err_early", 32'(err_timeout), 32'(0));
            if (k == ACKTO) begin
                check("to_err_set", 32'(err_timeout), 32'(1));
                check("to_arb", 32'(active), 32'(0));
            end
        end
        stuck = 1'b0;
        wait_idle("to");
        check("to_err_sticky", 32'(err_timeout), 32'(1));
        compare_obs("to");
        do_reset();
        @(posedge clk);
        #2;
        check("to_err_cleared", 32'(err_timeout), 32'(0));

        // Reset during WAIT_DONE
        blen = 6;
        @(negedge clk);
        clear_q();
        for (int b = 0; b < 3; b++) load(0, 8'(8'hD0 + b), 1'b0);
        n = 0;
        while (!(active && tx_busy) && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("mid_reached_busy", 32'(active && tx_busy), 32'(1));
        @(posedge clk);
        #2;
        @(negedge clk);
        reset = 1'b1;
        m_ptr = 0;
        clear_q();
        @(posedge clk);
        #2;
        check("mid_tx_start", 32'(tx_start), 32'(0));
        check("mid_tx_data", 32'(tx_data), 32'(0));
        check("mid_ready", 32'(req_ready), 32'(0));
        check("mid_active", 32'(active), 32'(0));
        check("mid_grant", 32'(grant_id), 32'(0));
        repeat (3) begin
            @(posedge clk);
            #2;
            check("mid_no_start", 32'(tx_start), 32'(0));
        end
        @(negedge clk);
        reset = 1'b0;
        obs_q.delete();
        exp_q.delete();

        // Randomized traffic against the model
        for (int it = 0; it < 8; it++) begin
            int cnt;
            @(negedge clk);
            clear_q();
            blen = $urandom_range(1, 4);
            for (int i = 0; i < NREQ; i++) begin
                cnt = $urandom_range(0, 4);
                if (it == 0 && i == 0 && cnt == 0) cnt = 1;
                for (int b = 0; b < cnt; b++)
                    load(i, 8'($urandom), 1'($urandom_range(0, 2) == 0));
            end
            model_run();
            wait_idle("rand");
            compare_obs("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0d exp=done", total);
        $fatal(1);
    end

endmodule
